sdf_r2_stage_p: RTL and testbench

//  Parametrised radix-2 single-path delay-feedback (SDF) FFT stage with an internal sample counter,

---
 rtl/sdf_r2_stage_p.sv | 229 ++++++++++++++++++++++
 tb/tb_sdf_r2_stage_p.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_r2_stage_p.sv
// Radix-2 single-path delay-feedback FFT stage: internal sample tagging, frame/valid tracking,
// optional 1-bit scaling and forward/inverse twiddle selection; twiddle ROM lives outside.
module sdf_r2_stage_p #(
    parameter int BW    = 16,
    parameter int N     = 64,
    parameter int TW_BW = 16,
    parameter int SCALE = 0,
    localparam int OW   = (SCALE != 0) ? BW : BW + 1,
    localparam int AW   = $clog2(N),
    localparam int CW   = $clog2(2 * N)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic                    inverse,
    input  logic signed [BW-1:0]    in_re,
    input  logic signed [BW-1:0]    in_im,
    output logic        [AW-1:0]    tw_addr,
    input  logic signed [TW_BW-1:0] tw_re,
    input  logic signed [TW_BW-1:0] tw_im,
    output logic                    out_valid,
    output logic                    out_sof,
    output logic signed [OW-1:0]    out_re,
    output logic signed [OW-1:0]    out_im
);

    localparam int DW = BW + 1;
    localparam int SW = BW + 2;
    localparam int MW = (SCALE != 0) ? BW : BW + 1;
    localparam int TX = TW_BW + 1;
    localparam int PW = MW + TW_BW + 2;
    localparam int SH = TW_BW - 2;

    localparam logic        [CW-1:0] TAG_N   = CW'(N);
    localparam logic        [CW-1:0] TAG_ONE = CW'(1'b1);
    localparam logic signed [SW-1:0] ONE_S   = $signed({{(SW-1){1'b0}}, 1'b1});
    localparam logic signed [PW-1:0] HALF_P  = $signed({{(PW-SH){1'b0}}, 1'b1, {(SH-1){1'b0}}});
    localparam logic signed [PW-1:0] MAX_P   = $signed({{(PW-OW+1){1'b0}}, {(OW-1){1'b1}}});
    localparam logic signed [PW-1:0] MIN_P   = $signed({{(PW-OW+1){1'b1}}, {(OW-1){1'b0}}});

    function automatic logic signed [SW-1:0] half_rnd(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] t;
        t = v + ONE_S;
        return t >>> 1;
    endfunction

    function automatic logic signed [PW-1:0] tw_rnd(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] t;
        t = v + HALF_P;
        return t >>> SH;
    endfunction

    function automatic logic signed [OW-1:0] sat_ow(input logic signed [PW-1:0] v);
        logic signed [OW-1:0] r;
        if (v > MAX_P) begin
            r = MAX_P[OW-1:0];
        end else if (v < MIN_P) begin
            r = MIN_P[OW-1:0];
        end else begin
            r = v[OW-1:0];
        end
        return r;
    endfunction

    logic        [CW-1:0] cnt_r;
    logic                 primed_r;
    logic                 inv_r;
    logic                 s1_valid_r;
    logic                 s1_sof_r;
    logic signed [BW-1:0] s1_re_r;
    logic signed [BW-1:0] s1_im_r;
    logic        [CW-1:0] s1_tag_r;
    logic signed [DW-1:0] dl_re_r [N];
    logic signed [DW-1:0] dl_im_r [N];
    logic                 out_valid_r;
    logic                 out_sof_r;
    logic signed [OW-1:0] out_re_r;
    logic signed [OW-1:0] out_im_r;

    logic        [CW-1:0] tag_s;
    logic                 abrupt_s;
    logic                 primed_eff_s;
    logic                 sof_tag_s;
    logic                 phase_b_s;
    logic                 emit_s;
    logic signed [SW-1:0] sum_re_s, sum_im_s, dif_re_s, dif_im_s;
    logic signed [SW-1:0] p_re_s, p_im_s, m_re_s, m_im_s;
    logic signed [DW-1:0] dl_in_re_s, dl_in_im_s;
    logic signed [MW-1:0] mul_re_s, mul_im_s;
    logic signed [TX-1:0] twr_s, twi_s;
    logic signed [PW-1:0] prod_re_s, prod_im_s;
    logic signed [OW-1:0] res_re_s, res_im_s;

    // Input tagging: an sof always restarts at tag 0; it is abrupt when the counter was mid-frame.
    always_comb begin
        if (in_sof) begin
            tag_s = '0;
        end else begin
            tag_s = cnt_r;
        end
        abrupt_s     = in_valid & in_sof & (cnt_r != '0);
        primed_eff_s = primed_r & ~abrupt_s;
        sof_tag_s    = ((tag_s == '0) & primed_eff_s) | ((tag_s == TAG_N) & ~primed_eff_s);
    end

    // Butterfly, delay-line feed and twiddle multiply for the sample held in S1.
    always_comb begin
        phase_b_s = s1_tag_r[CW-1];
        sum_re_s  = SW'(dl_re_r[N-1]) + SW'(s1_re_r);
        sum_im_s  = SW'(dl_im_r[N-1]) + SW'(s1_im_r);
        dif_re_s  = SW'(dl_re_r[N-1]) - SW'(s1_re_r);
        dif_im_s  = SW'(dl_im_r[N-1]) - SW'(s1_im_r);
        if (SCALE != 0) begin
            p_re_s = half_rnd(sum_re_s);
            p_im_s = half_rnd(sum_im_s);
            m_re_s = half_rnd(dif_re_s);
            m_im_s = half_rnd(dif_im_s);
        end else begin
            p_re_s = sum_re_s;
            p_im_s = sum_im_s;
            m_re_s = dif_re_s;
            m_im_s = dif_im_s;
        end
        if (phase_b_s) begin
            dl_in_re_s = DW'(m_re_s);
            dl_in_im_s = DW'(m_im_s);
        end else begin
            dl_in_re_s = DW'(s1_re_r);
            dl_in_im_s = DW'(s1_im_r);
        end
        mul_re_s = MW'(dl_re_r[N-1]);
        mul_im_s = MW'(dl_im_r[N-1]);
        twr_s    = TX'(tw_re);
        // Negate in the widened format so the most negative twiddle cannot wrap.
        if (inv_r) begin
            twi_s = -TX'(tw_im);
        end else begin
            twi_s = TX'(tw_im);
        end
        prod_re_s = PW'(mul_re_s) * PW'(twr_s) - PW'(mul_im_s) * PW'(twi_s);
        prod_im_s = PW'(mul_re_s) * PW'(twi_s) + PW'(mul_im_s) * PW'(twr_s);
        if (phase_b_s) begin
            res_re_s = sat_ow(PW'(p_re_s));
            res_im_s = sat_ow(PW'(p_im_s));
            tw_addr  = '0;
        end else begin
            res_re_s = sat_ow(tw_rnd(prod_re_s));
            res_im_s = sat_ow(tw_rnd(prod_im_s));
            tw_addr  = s1_tag_r[AW-1:0];
        end
        emit_s = s1_valid_r & (phase_b_s | primed_r) & ~abrupt_s;
    end

    // S1 input register, sample counter, primed flag and per-frame inverse mode.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r      <= '0;
            primed_r   <= 1'b0;
            inv_r      <= 1'b0;
            s1_valid_r <= 1'b0;
            s1_sof_r   <= 1'b0;
            s1_re_r    <= '0;
            s1_im_r    <= '0;
            s1_tag_r   <= '0;
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                cnt_r    <= tag_s + TAG_ONE;
                s1_re_r  <= in_re;
                s1_im_r  <= in_im;
                s1_tag_r <= tag_s;
                s1_sof_r <= sof_tag_s;
                if (abrupt_s) begin
                    primed_r <= 1'b0;
                end else if (tag_s == TAG_N) begin
                    primed_r <= 1'b1;
                end
                if (in_sof) begin
                    inv_r <= inverse;
                end
            end else begin
                s1_re_r  <= '0;
                s1_im_r  <= '0;
                s1_sof_r <= 1'b0;
            end
        end
    end

    // Feedback delay line; an abrupt sof discards whatever the interrupted frame left behind.
    always_ff @(posedge clk) begin
        if (!reset_n || abrupt_s) begin
            for (int i = 0; i < N; i++) begin
                dl_re_r[i] <= '0;
                dl_im_r[i] <= '0;
            end
        end else if (s1_valid_r) begin
            dl_re_r[0] <= dl_in_re_s;
            dl_im_r[0] <= dl_in_im_s;
            for (int i = 1; i < N; i++) begin
                dl_re_r[i] <= dl_re_r[i-1];
                dl_im_r[i] <= dl_im_r[i-1];
            end
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_sof_r   <= 1'b0;
            out_re_r    <= '0;
            out_im_r    <= '0;
        end else begin
            out_valid_r <= emit_s;
            out_sof_r   <= emit_s & s1_sof_r;
            if (emit_s) begin
                out_re_r <= res_re_s;
                out_im_r <= res_im_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_sof   = out_sof_r;
    assign out_re    = out_re_r;
    assign out_im    = out_im_r;

endmodule

// File: tb/tb_sdf_r2_stage_p.sv
// Directed bench for sdf_r2_stage_p (N=4): one SCALE=0 and one SCALE=1 instance on shared stimulus.
module tb_sdf_r2_stage_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n, in_valid, in_sof, inverse;
    logic signed [15:0] in_re, in_im;
    logic        [1:0]  tw_addr, tw_addr_s;
    logic signed [15:0] tw_re, tw_im, tw_re_s, tw_im_s;
    logic               out_valid, out_sof, out_valid_s, out_sof_s;
    logic signed [16:0] out_re, out_im;
    logic signed [15:0] out_re_s, out_im_s;

    int n_checks = 0;
    int n_fail   = 0;
    int q_re[$], q_im[$], q_sof[$];
    int s_re[$], s_im[$], s_sof[$];
    int e_re[$], e_im[$], e_sof[$];
    int fv[8];

    sdf_r2_stage_p #(.BW(16), .N(4), .TW_BW(16), .SCALE(0)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sof(in_sof), .inverse(inverse),
        .in_re(in_re), .in_im(in_im), .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
        .out_valid(out_valid), .out_sof(out_sof), .out_re(out_re), .out_im(out_im)
    );

    sdf_r2_stage_p #(.BW(16), .N(4), .TW_BW(16), .SCALE(1)) dut_s (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sof(in_sof), .inverse(inverse),
        .in_re(in_re), .in_im(in_im), .tw_addr(tw_addr_s), .tw_re(tw_re_s), .tw_im(tw_im_s),
        .out_valid(out_valid_s), .out_sof(out_sof_s), .out_re(out_re_s), .out_im(out_im_s)
    );

    function automatic logic signed [15:0] rom_re(input logic [1:0] k);
        case (k)
            2'd0:    return 16'sd16384;
            2'd1:    return 16'sd11585;
            2'd2:    return 16'sd0;
            default: return -16'sd11585;
        endcase
    endfunction

    function automatic logic signed [15:0] rom_im(input logic [1:0] k);
        case (k)
            2'd0:    return 16'sd0;
            2'd1:    return -16'sd11585;
            2'd2:    return -16'sd16384;
            default: return -16'sd11585;
        endcase
    endfunction

    always_comb begin
        tw_re   = rom_re(tw_addr);
        tw_im   = rom_im(tw_addr);
        tw_re_s = rom_re(tw_addr_s);
        tw_im_s = rom_im(tw_addr_s);
    end

    always @(negedge clk) begin
        if (out_valid) begin
            q_re.push_back(int'(out_re));
            q_im.push_back(int'(out_im));
            q_sof.push_back(int'(out_sof));
        end
        if (out_valid_s) begin
            s_re.push_back(int'(out_re_s));
            s_im.push_back(int'(out_im_s));
            s_sof.push_back(int'(out_sof_s));
        end
    end

    task automatic chk_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        q_re.delete(); q_im.delete(); q_sof.delete();
        s_re.delete(); s_im.delete(); s_sof.delete();
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        clear_q();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input int re, input int im, input logic sof, input logic inv, input int gap);
        in_valid = 1'b1;
        in_sof   = sof;
        inverse  = inv;
        in_re    = 16'(re);
        in_im    = 16'(im);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_re    = '0;
        in_im    = '0;
        idle(gap);
    endtask

    // inverse is driven to the requested value only on the sof sample and flipped elsewhere.
    task automatic send_frame(input logic inv, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            send(fv[i], 0, (i == 0), (i == 0) ? inv : ~inv, gaps ? (i % 3) + 1 : 0);
        end
    endtask

    task automatic check_q(input string name, input bit use_s, input int n_total);
        int a_re[$], a_im[$], a_sof[$];
        if (use_s) begin
            a_re = s_re; a_im = s_im; a_sof = s_sof;
        end else begin
            a_re = q_re; a_im = q_im; a_sof = q_sof;
        end
        chk_val({name, "_count"}, a_re.size(), n_total);
        for (int i = 0; i < e_re.size(); i++) begin
            if (i < a_re.size()) begin
                chk_val($sformatf("%s_re[%0d]", name, i), a_re[i], e_re[i]);
                chk_val($sformatf("%s_im[%0d]", name, i), a_im[i], e_im[i]);
                chk_val($sformatf("%s_sof[%0d]", name, i), a_sof[i], e_sof[i]);
            end
        end
    endtask

    task automatic impulse_run(input bit gaps);
        fv = '{1000, 0, 0, 0, 0, 0, 0, 0};
        send_frame(1'b0, gaps);
        fv = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(1'b0, gaps);
        idle(3);
        e_re  = '{1000, 0, 0, 0, 1000, 0, 0, 0, 0, 0, 0, 0};
        e_im  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        e_sof = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        inverse  = 1'b0;
        in_re    = '0;
        in_im    = '0;
        idle(2);
        do_reset();
        chk_val("rst_out_valid", int'(out_valid), 0);
        chk_val("rst_out_sof", int'(out_sof), 0);
        chk_val("rst_out_re", int'(out_re), 0);
        chk_val("rst_out_im", int'(out_im), 0);
        chk_val("rst_tw_addr", int'(tw_addr), 0);

        impulse_run(1'b0);
        check_q("impulse", 1'b0, 12);

        do_reset();
        fv = '{100, 100, 100, 100, 100, 100, 100, 100};
        send_frame(1'b0, 1'b0);
        fv = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(1'b0, 1'b0);
        idle(3);
        e_re  = '{200, 200, 200, 200, 0, 0, 0, 0, 0, 0, 0, 0};
        e_im  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        e_sof = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        check_q("dc", 1'b0, 12);

        for (int inv = 0; inv < 2; inv++) begin
            do_reset();
            fv = '{0, 0, 0, 0, 0, 1000, 0, 0};
            send_frame(inv[0], 1'b0);
            fv = '{0, 0, 0, 0, 0, 0, 0, 0};
            send_frame(inv[0], 1'b0);
            idle(3);
            e_re  = '{0, 1000, 0, 0, 0, -707, 0, 0, 0, 0, 0, 0};
            e_im  = '{0, 0, 0, 0, 0, (inv != 0) ? -707 : 707, 0, 0, 0, 0, 0, 0};
            e_sof = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
            check_q((inv != 0) ? "inverse" : "twiddle", 1'b0, 12);
        end

        do_reset();
        fv = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        send_frame(1'b0, 1'b0);
        fv = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        send_frame(1'b0, 1'b0);
        fv = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(1'b0, 1'b0);
        idle(3);
        e_re  = '{32767, 32767, 32767, 32767, 0, 0, 0, 0, -32768, -32768, -32768, -32768};
        e_im  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        e_sof = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        check_q("scale1", 1'b1, 20);

        do_reset();
        impulse_run(1'b1);
        check_q("gaps", 1'b0, 12);

        do_reset();
        fv = '{100, 100, 100, 100, 40, 40, 40, 40};
        send_frame(1'b0, 1'b0);
        send(7, 0, 1'b1, 1'b0, 0);
        send(7, 0, 1'b0, 1'b0, 0);
        fv = '{50, 50, 50, 50, 50, 50, 50, 50};
        send_frame(1'b0, 1'b0);
        idle(3);
        e_re  = '{140, 140, 140, 140, 60, 100, 100, 100, 100};
        e_im  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        e_sof = '{1, 0, 0, 0, 1, 1, 0, 0, 0};
        check_q("abrupt", 1'b0, 9);

        do_reset();
        fv = '{100, 100, 100, 100, 40, 40, 40, 40};
        send_frame(1'b0, 1'b0);
        send(0, 0, 1'b1, 1'b0, 0);
        idle(1);
        chk_val("pre_rst_valid", int'(out_valid), 1);
        chk_val("pre_rst_re", int'(out_re), 60);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk_val("mid_rst_valid", int'(out_valid), 0);
        chk_val("mid_rst_sof", int'(out_sof), 0);
        chk_val("mid_rst_re", int'(out_re), 0);
        chk_val("mid_rst_im", int'(out_im), 0);
        reset_n = 1'b1;
        clear_q();
        impulse_run(1'b0);
        check_q("post_rst", 1'b0, 12);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
